// File: rtl/pentary_sa_cache.sv
// Write-back, write-allocate set-associative cache: tree PLRU, invalid-way-first allocation, whole-cache flush.
// Optional feature macro: PENTARY_CACHE_STATS_EN builds the saturating hit/miss counters.
module pentary_sa_cache #(
  parameter int ADDR_W     = 48,
  parameter int WORD_W     = 48,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 64,
  parameter int WAYS       = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic                                     req_we,
  input  logic [ADDR_W-1:0]                        req_addr,
  input  logic [WORD_W-1:0]                        req_wdata,
  output logic                                     resp_valid,
  output logic [WORD_W-1:0]                        resp_rdata,
  input  logic                                     flush_req,
  output logic                                     flush_done,
  output logic                                     mem_valid,
  input  logic                                     mem_ready,
  output logic                                     mem_we,
  output logic [ADDR_W-$clog2(LINE_WORDS)-1:0]     mem_addr,
  output logic [LINE_WORDS*WORD_W-1:0]             mem_wdata,
  input  logic [LINE_WORDS*WORD_W-1:0]             mem_rdata,
  output logic [31:0]                              stat_hits,
  output logic [31:0]                              stat_misses
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = LINE_WORDS * WORD_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FETCH, S_FILL, S_FL_SCAN, S_FL_WB} state_t;

  state_t             r_state;
  logic               r_we;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic [OFF_W-1:0]   r_off;
  logic [WORD_W-1:0]  r_wdata;
  logic [WAY_W-1:0]   r_vway;
  logic [LINE_W-1:0]  r_line;
  logic [IDX_W-1:0]   r_fset;
  logic [WAY_W-1:0]   r_fway;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [WAYS-2:0]    r_plru  [SETS];
  logic [TAG_W-1:0]   r_tags  [SETS][WAYS];
  logic [LINE_W-1:0]  r_data  [SETS][WAYS];

  logic               w_hit, w_inv, w_flast;
  logic [WAY_W-1:0]   w_hway, w_iway, w_victim;

  // Tree bits in heap order: node n (1-based) is bit n-1; a set bit means the victim lies right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] b);
    int n;
    n = 1;
    for (int l = 0; l < WAY_W; l++) n = 2 * n + int'(b[n-1]);
    return WAY_W'(n - WAYS);
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b, input logic [WAY_W-1:0] w);
    logic [WAYS-2:0] r;
    int n;
    r = b;
    n = int'(w) + WAYS;
    for (int l = 0; l < WAY_W; l++) begin
      r[(n >> 1) - 1] = ~n[0];
      n = n >> 1;
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] ln, input logic [OFF_W-1:0] off);
    return ln[int'(off)*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] ln, input logic [OFF_W-1:0] off,
                                                 input logic [WORD_W-1:0] wd);
    logic [LINE_W-1:0] r;
    r = ln;
    r[int'(off)*WORD_W +: WORD_W] = wd;
    return r;
  endfunction

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    w_inv  = 1'b0;
    w_iway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[r_idx][w] && (r_tags[r_idx][w] == r_tag)) begin
        w_hit  = 1'b1;
        w_hway = WAY_W'(w);
      end
      if (!r_valid[r_idx][w]) begin
        w_inv  = 1'b1;
        w_iway = WAY_W'(w);
      end
    end
    w_victim = w_inv ? w_iway : plru_victim(r_plru[r_idx]);
  end

  assign w_flast   = (r_fset == IDX_W'(SETS - 1)) && (r_fway == WAY_W'(WAYS - 1));
  assign req_ready = (r_state == S_IDLE) && !flush_req && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vway  <= '0;
      r_fset  <= '0;
      r_fway  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_state <= S_FL_SCAN;
            r_fset  <= '0;
            r_fway  <= '0;
          end else if (req_valid) begin
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_plru[r_idx] <= plru_touch(r_plru[r_idx], w_hway);
            if (r_we) r_dirty[r_idx][w_hway] <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_vway  <= w_victim;
            r_state <= (r_valid[r_idx][w_victim] && r_dirty[r_idx][w_victim]) ? S_WB : S_FETCH;
          end
        end
        S_WB:    if (mem_ready) r_state <= S_FETCH;
        S_FETCH: if (mem_ready) r_state <= S_FILL;
        S_FILL: begin
          r_valid[r_idx][r_vway] <= 1'b1;
          r_dirty[r_idx][r_vway] <= r_we;
          r_plru[r_idx]          <= plru_touch(r_plru[r_idx], r_vway);
          r_state                <= S_IDLE;
        end
        S_FL_SCAN: begin
          if (r_dirty[r_fset][r_fway]) begin
            r_state <= S_FL_WB;
          end else if (w_flast) begin
            r_state <= S_IDLE;
          end else if (r_fway == WAY_W'(WAYS - 1)) begin
            r_fway <= '0;
            r_fset <= r_fset + IDX_W'(1);
          end else begin
            r_fway <= r_fway + WAY_W'(1);
          end
        end
        S_FL_WB: begin
          if (mem_ready) begin
            r_dirty[r_fset][r_fway] <= 1'b0;
            r_state                 <= S_FL_SCAN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath storage carries no reset; validity is tracked by the control bits above.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          r_we    <= req_we;
          r_tag   <= req_addr[ADDR_W-1 -: TAG_W];
          r_idx   <= req_addr[OFF_W +: IDX_W];
          r_off   <= req_addr[OFF_W-1:0];
          r_wdata <= req_wdata;
        end
      end
      S_LOOKUP: if (w_hit && r_we) r_data[r_idx][w_hway] <= put_word(r_data[r_idx][w_hway], r_off, r_wdata);
      S_FETCH:  if (mem_ready) r_line <= mem_rdata;
      S_FILL: begin
        r_tags[r_idx][r_vway] <= r_tag;
        r_data[r_idx][r_vway] <= r_we ? put_word(r_line, r_off, r_wdata) : r_line;
      end
      default: ;
    endcase
  end

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = '0;
    flush_done = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      S_LOOKUP: begin
        resp_valid = w_hit;
        if (w_hit && !r_we) resp_rdata = get_word(r_data[r_idx][w_hway], r_off);
      end
      S_FILL: begin
        resp_valid = 1'b1;
        if (!r_we) resp_rdata = get_word(r_line, r_off);
      end
      S_WB: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_tags[r_idx][r_vway], r_idx};
        mem_wdata = r_data[r_idx][r_vway];
      end
      S_FETCH: begin
        mem_valid = 1'b1;
        mem_addr  = {r_tag, r_idx};
      end
      S_FL_SCAN: flush_done = w_flast && !r_dirty[r_fset][r_fway];
      S_FL_WB: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_tags[r_fset][r_fway], r_fset};
        mem_wdata = r_data[r_fset][r_fway];
      end
      default: ;
    endcase
  end

`ifdef PENTARY_CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  logic [31:0] r_hits, r_misses;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) r_hits   <= sat_inc(r_hits);
      else       r_misses <= sat_inc(r_misses);
    end
  end
  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif
endmodule

// File: tb/tb_pentary_sa_cache.sv
// Bench for pentary_sa_cache: request table with response/memory scoreboards, plus flush and reset-in-fetch sequences.
module tb_pentary_sa_cache;
  localparam int LA_W = 45;
`ifdef PENTARY_CACHE_STATS_EN
  localparam logic [31:0] EXP_HITS = 1, EXP_MISSES = 1;
`else
  localparam logic [31:0] EXP_HITS = 0, EXP_MISSES = 0;
`endif

  logic clk, reset;
  logic req_valid, req_ready, req_we;
  logic [47:0] req_addr, req_wdata;
  logic resp_valid;
  logic [47:0] resp_rdata;
  logic flush_req, flush_done;
  logic mem_valid, mem_ready, mem_we;
  logic [LA_W-1:0] mem_addr;
  logic [383:0] mem_wdata, mem_rdata;
  logic [31:0] stat_hits, stat_misses;

  pentary_sa_cache dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [47:0]     addr;
    logic [47:0]     wdata;
    logic [47:0]     exp_rdata;
    int              nmem;
    logic            m0_we;
    logic [LA_W-1:0] m0_addr;
    logic [47:0]     m0_w1;
    logic [LA_W-1:0] m1_addr;
  } vec_t;

  typedef struct {
    logic            we;
    logic [LA_W-1:0] addr;
    logic [47:0]     w1;
  } mt_t;

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int mem_cnt = 0;
  logic hold_mem = 1'b0;
  logic [47:0] resp_q[$];
  mt_t mem_q[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing memory contents: line 0x8 holds k+1, other lines tag their words with the line address.
  function automatic logic [47:0] dword(input logic [LA_W-1:0] la, input int k);
    if (la == 45'h8) return 48'(k + 1);
    return {la[39:0], 8'h00} | 48'(k + 1);
  endfunction

  function automatic logic [383:0] mk_line(input logic [LA_W-1:0] la);
    logic [383:0] l;
    for (int k = 0; k < 8; k++) l[k*48 +: 48] = dword(la, k);
    return l;
  endfunction

  function automatic vec_t mkv(input logic we, input logic [47:0] addr, input logic [47:0] wd,
                               input logic [47:0] exp, input int nmem, input logic m0we,
                               input logic [LA_W-1:0] m0a, input logic [47:0] m0w1, input logic [LA_W-1:0] m1a);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.exp_rdata = exp; v.nmem = nmem;
    v.m0_we = m0we; v.m0_addr = m0a; v.m0_w1 = m0w1; v.m1_addr = m1a;
    return v;
  endfunction

  // Memory responder: checks each new transfer against the expected queue, answers after two cycles.
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else if (mem_valid && !mem_ready) begin
      if (mem_cnt == 0) begin
        if (mem_we) n_wr++;
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_unexpected: got we=%0b addr=0x%0h expected no transfer", mem_we, mem_addr);
        end else begin
          mt_t e;
          e = mem_q.pop_front();
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) chk("mem_wb_word1", 64'(mem_wdata[48 +: 48]), 64'(e.w1));
        end
      end
      mem_cnt++;
      if (mem_cnt >= 2 && !hold_mem) begin
        mem_ready = 1'b1;
        mem_rdata = mk_line(mem_addr);
      end
    end else begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got rdata=0x%0h expected no response", resp_rdata);
      end else begin
        logic [47:0] e;
        e = resp_q.pop_front();
        chk("resp_rdata", 64'(resp_rdata), 64'(e));
      end
    end
  end

  task automatic do_req(input vec_t v);
    int n;
    mt_t e;
    resp_q.push_back(v.exp_rdata);
    if (v.nmem > 0) begin
      e.we = v.m0_we; e.addr = v.m0_addr; e.w1 = v.m0_w1;
      mem_q.push_back(e);
    end
    if (v.nmem > 1) begin
      e.we = 1'b0; e.addr = v.m1_addr; e.w1 = '0;
      mem_q.push_back(e);
    end
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_accepted", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 100) begin @(negedge clk); n++; end
    chk("resp_seen", 64'(resp_valid), 64'd1);
    if (v.nmem == 0) begin
      chk("hit_latency", 64'(n), 64'd1);
      chk("ready_low_in_lookup", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    chk("ready_after_resp", 64'(req_ready), 64'd1);
    chk("mem_traffic_done", 64'(mem_q.size()), 64'd0);
  endtask

  task automatic do_flush(output int n_done);
    int n;
    n_done = 0;
    n = 0;
    flush_req = 1'b1;
    #1 chk("ready_low_on_flush", 64'(req_ready), 64'd0);
    while (n_done == 0 && n < 3000) begin
      @(negedge clk);
      if (flush_done) n_done++;
      n++;
    end
    flush_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (flush_done) n_done++;
    end
  endtask

  initial begin
    int n, nd;
    mt_t e;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    flush_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;

    vecs[0]  = mkv(0, 48'h40,  0,       48'h1,     1, 0, 45'h8,   0,        0);
    vecs[1]  = mkv(0, 48'h43,  0,       48'h4,     0, 0, 0,       0,        0);
    vecs[2]  = mkv(1, 48'h41,  48'hABC, 48'h0,     0, 0, 0,       0,        0);
    vecs[3]  = mkv(0, 48'h41,  0,       48'hABC,   0, 0, 0,       0,        0);
    vecs[4]  = mkv(0, 48'h240, 0,       48'h4801,  1, 0, 45'h48,  0,        0);
    vecs[5]  = mkv(0, 48'h440, 0,       48'h8801,  1, 0, 45'h88,  0,        0);
    vecs[6]  = mkv(0, 48'h640, 0,       48'hC801,  1, 0, 45'hC8,  0,        0);
    vecs[7]  = mkv(0, 48'h43,  0,       48'h4,     0, 0, 0,       0,        0);
    vecs[8]  = mkv(0, 48'h840, 0,       48'h10801, 1, 0, 45'h108, 0,        0);
    vecs[9]  = mkv(0, 48'h240, 0,       48'h4801,  0, 0, 0,       0,        0);
    vecs[10] = mkv(0, 48'h440, 0,       48'h8801,  1, 0, 45'h88,  0,        0);
    vecs[11] = mkv(0, 48'h640, 0,       48'hC801,  2, 1, 45'h8,   48'hABC,  45'hC8);
    vecs[12] = mkv(0, 48'hA40, 0,       48'h14801, 1, 0, 45'h148, 0,        0);
    vecs[13] = mkv(1, 48'h10,  48'h111, 48'h0,     1, 0, 45'h2,   0,        0);
    vecs[14] = mkv(1, 48'h21,  48'h222, 48'h0,     1, 0, 45'h4,   0,        0);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata_any", 64'(|mem_wdata), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_stat_hits", 64'(stat_hits), 64'd0);
    chk("rst_stat_misses", 64'(stat_misses), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i]);
      if (i == 1) begin
        chk("stat_hits", 64'(stat_hits), 64'(EXP_HITS));
        chk("stat_misses", 64'(stat_misses), 64'(EXP_MISSES));
      end
    end

    // Flush: the two dirty lines are written back in set order.
    e.we = 1'b1; e.addr = 45'h2; e.w1 = 48'h202; mem_q.push_back(e);
    e.we = 1'b1; e.addr = 45'h4; e.w1 = 48'h222; mem_q.push_back(e);
    n_wr = 0;
    do_flush(nd);
    chk("flush_done_pulses", 64'(nd), 64'd1);
    chk("flush_writebacks", 64'(n_wr), 64'd2);
    chk("flush_queue_drained", 64'(mem_q.size()), 64'd0);
    do_req(mkv(0, 48'h10, 0, 48'h111, 0, 0, 0, 0, 0));
    n_wr = 0;
    do_flush(nd);
    chk("flush2_done_pulses", 64'(nd), 64'd1);
    chk("flush2_writebacks", 64'(n_wr), 64'd0);

    // Reset while a fetch is outstanding.
    e.we = 1'b0; e.addr = 45'h200; e.w1 = '0; mem_q.push_back(e);
    hold_mem = 1'b1;
    req_we = 1'b0; req_addr = 48'h1000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_valid && n < 20) begin @(negedge clk); n++; end
    chk("fetch_started", 64'(mem_valid), 64'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_stat_hits", 64'(stat_hits), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold_mem = 1'b0;
    @(negedge clk);
    chk("midrst_queue_drained", 64'(mem_q.size()), 64'd0);
    do_req(mkv(0, 48'h10, 0, 48'h201, 1, 0, 45'h2, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
